// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 3x3 keypad scanner and its debounce stage.
//   - Matrix geometry (NUM_ROWS, NUM_COLS, NUM_KEYS)
//   - Special frame codes KEY_NONE / KEY_MULTI
//   - Debounce state encoding
//   - frame_t: one frame code plus its one-cycle valid flag
//   - Helpers: is_key() and encode_frame()
package keypad_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_MULTI = 4'hF;

    localparam logic [1:0] ST_IDLE            = 2'd0;
    localparam logic [1:0] ST_CONFIRM_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD            = 2'd2;
    localparam logic [1:0] ST_CONFIRM_RELEASE = 2'd3;

    typedef struct packed {
        logic [3:0] code;
        logic       valid;
    } frame_t;

    // True for a single real key code 1..9 (never NONE or MULTI).
    function automatic logic is_key(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd9);
    endfunction

    // Reduce a full-frame pressed map (bit r*3+c, active-high) to a frame code.
    function automatic logic [3:0] encode_frame(input logic [NUM_KEYS-1:0] pressed);
        logic [3:0] hits;
        logic [3:0] code;
        hits = 4'd0;
        code = KEY_NONE;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pressed[i]) begin
                hits = hits + 4'd1;
                code = 4'(i + 1);
            end
        end
        if (hits > 4'd1) begin
            code = KEY_MULTI;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// key_debounce
// Debounce FSM fed with one frame code per completed keypad frame.
//   clk_i          in   system clock
//   rst_ni         in   asynchronous active-low reset
//   frame_code_i   in   4-bit frame code (NONE, 1..9, MULTI)
//   frame_valid_i  in   one-cycle strobe marking a new frame code
//   button_o       out  last accepted key code (0 until the first press)
//   bstate_o       out  high while the accepted key is held
//   press_o        out  one-cycle strobe on the cycle bstate_o rises
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] frame_code_i,
    input  logic       frame_valid_i,
    output logic [3:0] button_o,
    output logic       bstate_o,
    output logic       press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    // With a single-frame requirement the confirm states are skipped entirely.
    localparam bit SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       cand_q,   cand_d;
    logic [3:0]       button_q, button_d;
    logic             bstate_q, bstate_d;
    logic             press_q,  press_d;
    logic [CNT_W-1:0] cnt_inc_s;

    // Saturating increment of the matching-frame counter.
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // Next-state logic: evaluated only on frame-complete strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        button_d = button_q;
        bstate_d = bstate_q;
        press_d  = 1'b0;
        if (frame_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_key(frame_code_i)) begin
                        cand_d = frame_code_i;
                        if (SINGLE_SCAN) begin
                            state_d  = ST_HELD;
                            cnt_d    = CNT_ZERO;
                            button_d = frame_code_i;
                            bstate_d = 1'b1;
                            press_d  = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM_PRESS;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_CONFIRM_PRESS: begin
                    if (frame_code_i == cand_q) begin
                        if (cnt_inc_s == CNT_MAX) begin
                            state_d  = ST_HELD;
                            cnt_d    = CNT_ZERO;
                            button_d = cand_q;
                            bstate_d = 1'b1;
                            press_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc_s;
                        end
                    end else begin
                        // Aborting frame is discarded, not taken as a new candidate.
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_HELD: begin
                    if (frame_code_i == button_q) begin
                        state_d = ST_HELD;
                    end else if (SINGLE_SCAN) begin
                        state_d  = ST_IDLE;
                        cnt_d    = CNT_ZERO;
                        bstate_d = 1'b0;
                    end else begin
                        state_d = ST_CONFIRM_RELEASE;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_CONFIRM_RELEASE: begin
                    if (frame_code_i == button_q) begin
                        state_d = ST_HELD;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_inc_s == CNT_MAX) begin
                        state_d  = ST_IDLE;
                        cnt_d    = CNT_ZERO;
                        bstate_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cnt_d    = CNT_ZERO;
                    bstate_d = 1'b0;
                end
            endcase
        end else begin
            press_d = 1'b0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            cand_q   <= KEY_NONE;
            button_q <= KEY_NONE;
            bstate_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            button_q <= button_d;
            bstate_q <= bstate_d;
            press_q  <= press_d;
        end
    end

    assign button_o = button_q;
    assign bstate_o = bstate_q;
    assign press_o  = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 3x3 matrix keypad one row at a time, synchronises the columns,
// builds one frame code per full scan and debounces it into a clean key.
//   hwclk        in   system clock
//   resetN       in   asynchronous active-low reset
//   keypad_r1..3 out  active-low row drives, exactly one low at a time
//   keypad_c1..3 in   pulled-up columns, low = key in driven row pressed
//   button       out  debounced key code 1..9 (0 until the first press)
//   bstate       out  high while the debounced key is held
//   press        out  one-cycle strobe when bstate rises
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 12000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       hwclk,
    input  logic       resetN,
    output logic       keypad_r1,
    output logic       keypad_r2,
    output logic       keypad_r3,
    input  logic       keypad_c1,
    input  logic       keypad_c2,
    input  logic       keypad_c3,
    output logic [3:0] button,
    output logic       bstate,
    output logic       press
);

    localparam int SLOT_W = $clog2(SCAN_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    logic [SLOT_W-1:0]   slot_q,    slot_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [2:0]          row_n_q,   row_n_d;
    logic [2:0]          col_meta_q;
    logic [2:0]          col_sync_q;
    logic [NUM_COLS-1:0] cap0_q,    cap0_d;
    logic [NUM_COLS-1:0] cap1_q,    cap1_d;
    frame_t              frame_q,   frame_d;
    logic                slot_end_s;
    logic [NUM_COLS-1:0] pressed_s;

    assign slot_end_s = (slot_q == SLOT_LAST);
    assign pressed_s  = ~col_sync_q;

    // Two-flop column synchronisers; reset to the idle (pulled-up) level.
    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
        end else begin
            col_meta_q <= {keypad_c3, keypad_c2, keypad_c1};
            col_sync_q <= col_meta_q;
        end
    end

    // Slot counter, row rotation, per-row capture and frame encoding.
    always_comb begin
        slot_d       = slot_q;
        row_idx_d    = row_idx_q;
        row_n_d      = row_n_q;
        cap0_d       = cap0_q;
        cap1_d       = cap1_q;
        frame_d.code = frame_q.code;
        frame_d.valid = 1'b0;
        if (slot_end_s) begin
            slot_d = SLOT_ZERO;
            case (row_idx_q)
                2'd0: begin
                    cap0_d    = pressed_s;
                    row_idx_d = 2'd1;
                    row_n_d   = 3'b101;
                end
                2'd1: begin
                    cap1_d    = pressed_s;
                    row_idx_d = 2'd2;
                    row_n_d   = 3'b011;
                end
                2'd2: begin
                    // Row 3 capture closes the frame using the two stored rows.
                    frame_d.code  = encode_frame({pressed_s, cap1_q, cap0_q});
                    frame_d.valid = 1'b1;
                    row_idx_d     = 2'd0;
                    row_n_d       = 3'b110;
                end
                default: begin
                    row_idx_d = 2'd0;
                    row_n_d   = 3'b110;
                end
            endcase
        end else begin
            slot_d = slot_q + SLOT_ONE;
        end
    end

    // Scan registers; reset returns to row slot 0 and drops any partial frame.
    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            slot_q    <= SLOT_ZERO;
            row_idx_q <= 2'd0;
            row_n_q   <= 3'b110;
            cap0_q    <= {NUM_COLS{1'b0}};
            cap1_q    <= {NUM_COLS{1'b0}};
            frame_q   <= '{code: KEY_NONE, valid: 1'b0};
        end else begin
            slot_q    <= slot_d;
            row_idx_q <= row_idx_d;
            row_n_q   <= row_n_d;
            cap0_q    <= cap0_d;
            cap1_q    <= cap1_d;
            frame_q   <= frame_d;
        end
    end

    assign keypad_r1 = row_n_q[0];
    assign keypad_r2 = row_n_q[1];
    assign keypad_r3 = row_n_q[2];

    key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_i         (hwclk),
        .rst_ni        (resetN),
        .frame_code_i  (frame_q.code),
        .frame_valid_i (frame_q.valid),
        .button_o      (button),
        .bstate_o      (bstate),
        .press_o       (press)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench: table vectors, hand sequences for the multi-frame
// corner cases, and a randomized run checked cycle by cycle against a
// frame-level reference model. A second instance runs with a one-frame
// debounce requirement.
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 3;

    logic       hwclk = 1'b0;
    logic       resetN = 1'b0;
    logic       keypad_r1, keypad_r2, keypad_r3;
    logic       keypad_c1, keypad_c2, keypad_c3;
    logic [3:0] button;
    logic       bstate, press;
    logic       b_r1, b_r2, b_r3;
    logic [3:0] b_button;
    logic       b_bstate, b_press;

    logic [8:0] keys = 9'd0;
    logic [2:0] rows_s;
    logic [2:0] cols_s;

    int total = 0;
    int bad = 0;
    int n = 0;
    int press_cnt = 0;
    int press1_cnt = 0;

    always #5 hwclk = ~hwclk;

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_SCANS(DEB)) dut (
        .hwclk(hwclk), .resetN(resetN),
        .keypad_r1(keypad_r1), .keypad_r2(keypad_r2), .keypad_r3(keypad_r3),
        .keypad_c1(keypad_c1), .keypad_c2(keypad_c2), .keypad_c3(keypad_c3),
        .button(button), .bstate(bstate), .press(press)
    );

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_SCANS(1)) dut1 (
        .hwclk(hwclk), .resetN(resetN),
        .keypad_r1(b_r1), .keypad_r2(b_r2), .keypad_r3(b_r3),
        .keypad_c1(keypad_c1), .keypad_c2(keypad_c2), .keypad_c3(keypad_c3),
        .button(b_button), .bstate(b_bstate), .press(b_press)
    );

    assign rows_s = {keypad_r3, keypad_r2, keypad_r1};

    // Keypad: column c is pulled low while row r is driven low and key (r,c) is down.
    always_comb begin
        cols_s = 3'b111;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!rows_s[r] && keys[r*3+c]) cols_s[c] = 1'b0;
            end
        end
    end
    assign keypad_c1 = cols_s[0];
    assign keypad_c2 = cols_s[1];
    assign keypad_c3 = cols_s[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        n++;
        #1;
        if (press === 1'b1) press_cnt++;
        if (b_press === 1'b1) press1_cnt++;
    endtask

    task automatic goto(input int target);
        while (n < target) tick();
    endtask

    // Assert reset between edges, check the reset state, release on a falling edge.
    task automatic do_reset(input logic [8:0] k);
        @(negedge hwclk);
        resetN = 1'b0;
        keys = k;
        #3;
        check("reset state", {rows_s, press, bstate, button}, {3'b110, 1'b0, 1'b0, 4'd0});
        @(negedge hwclk);
        resetN = 1'b1;
        n = 0;
        press_cnt = 0;
        press1_cnt = 0;
    endtask

    // Reference model, one step per completed frame.
    logic [3:0] hist[$];
    logic       m_held;
    logic [3:0] m_button;
    logic       exp_press;

    function automatic logic [3:0] ref_code(input logic [8:0] k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 0; i < 9; i++) begin
            if (k[i]) begin
                cnt++;
                pos = i + 1;
            end
        end
        if (cnt == 0) return 4'd0;
        if (cnt > 1) return 4'hF;
        return 4'(pos);
    endfunction

    task automatic model_frame(input logic [3:0] code);
        exp_press = 1'b0;
        if (!m_held) begin
            if (code >= 4'd1 && code <= 4'd9) begin
                if (hist.size() == 0 || hist[$] == code) hist.push_back(code);
                else hist.delete();
            end else begin
                hist.delete();
            end
            if (hist.size() == DEB) begin
                m_held = 1'b1;
                m_button = code;
                exp_press = 1'b1;
                hist.delete();
            end
        end else begin
            if (code == m_button) begin
                hist.delete();
            end else begin
                hist.push_back(code);
                if (hist.size() == DEB) begin
                    m_held = 1'b0;
                    hist.delete();
                end
            end
        end
    endtask

    task automatic run_random(input int nframes);
        logic [8:0] seg_keys;
        logic [8:0] one9;
        logic [2:0] one3;
        logic [2:0] exp_rows;
        logic [3:0] cur_code;
        logic [3:0] prev_code;
        int seg_left;
        int kmax;
        int pick;
        seg_left = 0;
        seg_keys = 9'd0;
        one9 = 9'd1;
        one3 = 3'b001;
        prev_code = 4'd0;
        do_reset(9'd0);
        m_held = 1'b0;
        m_button = 4'd0;
        exp_press = 1'b0;
        hist.delete();
        for (int f = 1; f <= nframes + 1; f++) begin
            if (f <= nframes) begin
                if (seg_left == 0) begin
                    pick = $urandom_range(0, 99);
                    if (pick < 35) seg_keys = 9'd0;
                    else if (pick < 80) seg_keys = one9 << $urandom_range(0, 8);
                    else seg_keys = (one9 << $urandom_range(0, 8)) | (one9 << $urandom_range(0, 8));
                    seg_left = $urandom_range(1, 5);
                end
                keys = seg_keys;
                seg_left--;
                kmax = 12;
            end else begin
                kmax = 2;
            end
            cur_code = ref_code(keys);
            for (int k = 1; k <= kmax; k++) begin
                tick();
                if (k == 1 && f > 1) model_frame(prev_code);
                else exp_press = 1'b0;
                exp_rows = ~(one3 << ((n / SCAN) % 3));
                check("random cycle", {rows_s, press, bstate, button},
                      {exp_rows, exp_press, m_held, m_button});
            end
            prev_code = cur_code;
        end
    endtask

    typedef struct {
        logic [8:0] keys;
        logic       exp_bstate;
        logic [3:0] exp_button;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{9'h000, 1'b0, 4'd0};
        vecs[1] = '{9'h001, 1'b1, 4'd1};
        vecs[2] = '{9'h010, 1'b1, 4'd5};
        vecs[3] = '{9'h100, 1'b1, 4'd9};
        vecs[4] = '{9'h004, 1'b1, 4'd3};
        vecs[5] = '{9'h040, 1'b1, 4'd7};
        vecs[6] = '{9'h005, 1'b0, 4'd0};
        vecs[7] = '{9'h012, 1'b0, 4'd0};
        vecs[8] = '{9'h1FF, 1'b0, 4'd0};

        // Table: steady key pattern from reset; accept only at clock 37.
        for (int i = 0; i < 9; i++) begin
            do_reset(vecs[i].keys);
            goto(36);
            check("vec bstate@36", {31'd0, bstate}, 32'd0);
            goto(37);
            check("vec out@37", {bstate, press, button},
                  {vecs[i].exp_bstate, vecs[i].exp_bstate, vecs[i].exp_button});
        end

        // 1: key 5 from reset; one-frame instance accepts after frame 1.
        do_reset(9'h010);
        goto(12);
        check("t1 dut1 bstate@12", {31'd0, b_bstate}, 32'd0);
        goto(13);
        check("t1 dut1 out@13", {b_bstate, b_press, b_button}, {1'b1, 1'b1, 4'd5});
        check("t1 dut1 rows", {29'd0, b_r3, b_r2, b_r1}, {29'd0, rows_s});
        goto(36);
        check("t1 bstate@36", {31'd0, bstate}, 32'd0);
        goto(37);
        check("t1 out@37", {bstate, press, button}, {1'b1, 1'b1, 4'd5});
        goto(38);
        check("t1 strobe width", {press, 8'(press_cnt)}, {1'b0, 8'd1});

        // 2: release key 5 at a frame boundary.
        goto(48);
        keys = 9'd0;
        goto(60);
        check("t2 dut1 bstate@60", {31'd0, b_bstate}, 32'd1);
        goto(61);
        check("t2 dut1 out@61", {b_bstate, b_button, 8'(press1_cnt)}, {1'b0, 4'd5, 8'd1});
        goto(84);
        check("t2 bstate@84", {31'd0, bstate}, 32'd1);
        goto(85);
        check("t2 out@85", {bstate, button, 8'(press_cnt)}, {1'b0, 4'd5, 8'd1});

        // 3: key 9 bouncing for 30 clocks, then steady.
        do_reset(9'h100);
        for (int i = 1; i <= 6; i++) begin
            goto(5 * i);
            keys = keys ^ 9'h100;
        end
        goto(120);
        check("t3 bounce", {bstate, button, 8'(press_cnt)}, {1'b1, 4'd9, 8'd1});

        // 4: keys 1+3 for 10 frames, then key 1 alone.
        do_reset(9'h005);
        goto(120);
        check("t4 multi", {bstate, 8'(press_cnt)}, {1'b0, 8'd0});
        keys = 9'h001;
        goto(156);
        check("t4 bstate@156", {31'd0, bstate}, 32'd0);
        goto(157);
        check("t4 out@157", {bstate, press, button}, {1'b1, 1'b1, 4'd1});

        // 5: rollover from key 4 straight to key 7.
        do_reset(9'h008);
        goto(37);
        check("t5 press 4", {bstate, button}, {1'b1, 4'd4});
        goto(48);
        keys = 9'h040;
        goto(84);
        check("t5 bstate@84", {31'd0, bstate}, 32'd1);
        goto(85);
        check("t5 release", {bstate, button}, {1'b0, 4'd4});
        goto(120);
        check("t5 bstate@120", {31'd0, bstate}, 32'd0);
        goto(121);
        check("t5 press 7", {bstate, press, button, 8'(press_cnt)}, {1'b1, 1'b1, 4'd7, 8'd2});

        // 6: reset mid-confirm for key 2; row 2 is low at the reset moment.
        do_reset(9'h002);
        goto(28);
        check("t6 pre-reset rows", {29'd0, rows_s}, {29'd0, 3'b101});
        do_reset(9'h002);
        goto(36);
        check("t6 bstate@36", {31'd0, bstate}, 32'd0);
        goto(37);
        check("t6 out@37", {bstate, press, button}, {1'b1, 1'b1, 4'd2});

        // Randomized frames against the reference model.
        run_random(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
